i_memory: RTL

- MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM register outputs.
- Performs the data-memory access over a req/ack bus to an external data memory, and resolves the branch decision (pcsrc, branch target).
- Latches the MEM/WB pipeline register and raises `stall` to freeze upstream stages while an access is outstanding.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/mem_wb.sv | 47 ++++
 rtl/i_memory.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline stages.
// WB control layout, MEM FSM encoding and width defaults.
package pipeline_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Bit positions inside the 2-bit WB control bundle.
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    // Word accesses only: the two low address bits must be zero.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register.
// A bubble loads an all-zero entry so WB sees no write.
import pipeline_pkg::*;

module mem_wb #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble_i,
    input  logic [1:0]        wb_ctl_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [REG_W-1:0]  write_reg_i,
    output logic [1:0]        wb_ctl_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [REG_W-1:0]  write_reg_o
);

    logic [1:0]        wb_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] alu_q;
    logic [REG_W-1:0]  wreg_q;

    // Latch the stage result, or a bubble when nothing retires.
    always_ff @(posedge clk) begin
        if (rst || bubble_i) begin
            wb_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            wreg_q  <= '0;
        end else begin
            wb_q    <= wb_ctl_i;
            rdata_q <= read_data_i;
            alu_q   <= alu_result_i;
            wreg_q  <= write_reg_i;
        end
    end

    assign wb_ctl_o     = wb_q;
    assign read_data_o  = rdata_q;
    assign alu_result_o = alu_q;
    assign write_reg_o  = wreg_q;

endmodule

// File: rtl/i_memory.sv
// MEM stage: data-memory access over req/ack, branch resolve.
// Stalls upstream while a bus access is outstanding.
import pipeline_pkg::*;

module i_memory #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_ctl,
    input  logic              branch,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [DATA_W-1:0] ex_mem_npc,
    input  logic              zero,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [REG_W-1:0]  write_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              pcsrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              mem_err,
    output logic [1:0]        wb_ctlout,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  write_reg_out
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [1:0]        capwb_q, capwb_d;
    logic [REG_W-1:0]  capreg_q, capreg_d;

    logic              access;
    logic              aligned;
    logic              stall_c;
    logic              bubble;
    logic [1:0]        wb_ld;
    logic [DATA_W-1:0] rd_ld;
    logic [DATA_W-1:0] alu_ld;
    logic [REG_W-1:0]  wr_ld;

    assign access  = memread | memwrite;
    assign aligned = is_word_aligned(alu_result[1:0]);

    // Next-state, bus request and MEM/WB source selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        capwb_d  = capwb_q;
        capreg_d = capreg_q;
        stall_c  = 1'b0;
        bubble   = 1'b0;
        wb_ld    = wb_ctl;
        rd_ld    = '0;
        alu_ld   = alu_result;
        wr_ld    = write_reg;
        unique case (state_q)
            S_IDLE: begin
                if (access) begin
                    bubble = 1'b1;
                    if (!aligned) begin
                        err_d = 1'b1;
                    end else begin
                        stall_c  = 1'b1;
                        state_d  = S_WAIT;
                        cnt_d    = '0;
                        req_d    = 1'b1;
                        we_d     = memwrite;
                        addr_d   = alu_result;
                        wdata_d  = rdata2;
                        capwb_d  = wb_ctl;
                        capreg_d = write_reg;
                    end
                end
            end
            S_WAIT: begin
                stall_c = ~dmem_ack;
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wb_ld   = capwb_q;
                    rd_ld   = we_q ? '0 : dmem_rdata;
                    alu_ld  = addr_q;
                    wr_ld   = capreg_q;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    bubble  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    bubble = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                bubble  = 1'b1;
            end
        endcase
    end

    // FSM, timeout counter and registered bus signals.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            capwb_q  <= '0;
            capreg_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            capwb_q  <= capwb_d;
            capreg_q <= capreg_d;
        end
    end

    mem_wb #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .bubble_i     (bubble),
        .wb_ctl_i     (wb_ld),
        .read_data_i  (rd_ld),
        .alu_result_i (alu_ld),
        .write_reg_i  (wr_ld),
        .wb_ctl_o     (wb_ctlout),
        .read_data_o  (read_data),
        .alu_result_o (alu_result_out),
        .write_reg_o  (write_reg_out)
    );

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_err       = err_q;
    assign stall         = stall_c;
    assign pcsrc         = branch & zero & ~stall_c;
    assign branch_target = ex_mem_npc;

endmodule
